// File: rtl/cell_alu_pkg.sv
// Shared opcode definitions for the pipelined arithmetic/logic cell.
package cell_alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [OP_W-1:0] OP_SRL = 3'd6;
  localparam logic [OP_W-1:0] OP_SRA = 3'd7;

endpackage

// File: rtl/alu_ext_unit.sv
// Combinational execute unit: eight ALU ops plus operand0 bypass, with carry/borrow.
module alu_ext_unit
  import cell_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             byPass,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]  sum;
  logic [SH_W-1:0] sh;

  assign sum = {1'b0, a} + {1'b0, b};
  assign sh  = b[SH_W-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    if (byPass) begin
      result = a;
    end else begin
      case (op)
        OP_ADD: begin
          result = sum[WIDTH-1:0];
          carry  = sum[WIDTH];
        end
        OP_SUB: begin
          result = a - b;
          carry  = (a < b);
        end
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_SLL:  result = a << sh;
        OP_SRL:  result = a >> sh;
        OP_SRA:  result = $unsigned($signed(a) >>> sh);
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/cell_arithmetic_logic_pipelined.sv
// Two-stage valid/ready ALU cell: stage 1 captures selected operands, stage 2 executes
// against either operand1 or the running accumulator and registers result and flags.
module cell_arithmetic_logic_pipelined
  import cell_alu_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int N_INPUTS = 4,
  localparam int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INPUTS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel0,
  input  logic [SEL_W-1:0]          sel1,
  input  logic [OP_W-1:0]           selOp,
  input  logic                      byPass,
  input  logic                      accEn,
  input  logic                      accClr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out,
  output logic                      zero,
  output logic                      carry,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic             s1_bypass;
  logic             s1_acc_en;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             adv2;
  logic             accept;

  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  // Accumulator is read at execute, so a back-to-back accumulate sees the prior result.
  assign op1 = s1_acc_en ? acc : s1_b;

  alu_ext_unit #(.WIDTH(WIDTH)) u_alu (
    .a      (s1_a),
    .b      (op1),
    .op     (s1_op),
    .byPass (s1_bypass),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_bypass <= 1'b0;
      s1_acc_en <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_a      <= in_bus[int'(sel0)*WIDTH +: WIDTH];
        s1_b      <= in_bus[int'(sel1)*WIDTH +: WIDTH];
        s1_op     <= selOp;
        s1_bypass <= byPass;
        s1_acc_en <= accEn;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        out       <= alu_res;
        zero      <= (alu_res == '0);
        carry     <= alu_carry;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Clear takes priority over a write-back landing on the same edge.
      if (accClr) begin
        acc <= '0;
      end else if (adv2 && s1_acc_en) begin
        acc <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_cell_arithmetic_logic_pipelined.sv
// Self-checking bench: directed cases plus randomized traffic against an in-order reference model.
module tb_cell_arithmetic_logic_pipelined;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_bus;
  logic [1:0]   sel0, sel1;
  logic [2:0]   selOp;
  logic         byPass, accEn, accClr, in_valid, out_ready;
  logic         in_ready, zero, carry, out_valid;
  logic [31:0]  out;

  logic [63:0]  in_bus8;
  logic [2:0]   sel0_8, sel1_8, selOp8;
  logic         in_valid8, in_ready8, zero8, carry8, out_valid8;
  logic [7:0]   out8;

  int n_chk = 0;
  int n_fail = 0;
  int n_fire = 0;
  logic accepted;
  logic saw_stall;
  logic [31:0] m_acc;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  cell_arithmetic_logic_pipelined dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel0(sel0), .sel1(sel1), .selOp(selOp),
    .byPass(byPass), .accEn(accEn), .accClr(accClr), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .zero(zero), .carry(carry), .out_valid(out_valid), .out_ready(out_ready)
  );

  cell_arithmetic_logic_pipelined #(.WIDTH(8), .N_INPUTS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus8), .sel0(sel0_8), .sel1(sel1_8), .selOp(selOp8),
    .byPass(1'b0), .accEn(1'b0), .accClr(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
    .out(out8), .zero(zero8), .carry(carry8), .out_valid(out_valid8), .out_ready(1'b1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result as {carry, result}, straight from the opcode definitions.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic bp);
    logic [4:0] sh;
    sh = b[4:0];
    if (bp) return {1'b0, a};
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a << sh};
      3'd6:    return {1'b0, a >> sh};
      default: return {1'b0, 32'($signed(a) >>> sh)};
    endcase
  endfunction

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [31:0] a, b;
    logic [32:0] r;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_acc = '0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("out", out, q[0][31:0]);
          chk("zero", zero, q[0][31:0] == 32'd0);
          chk("carry", carry, q[0][32]);
          if (out_ready) begin
            void'(q.pop_front());
            n_fire++;
          end
        end
      end
      if (!in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) begin
        accepted = 1'b1;
        a = in_bus[int'(sel0)*32 +: 32];
        b = accEn ? m_acc : in_bus[int'(sel1)*32 +: 32];
        r = ref_alu(a, b, selOp, byPass);
        q.push_back(r);
        if (accEn) m_acc = r[31:0];
      end
      if (accClr) m_acc = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_txn(input logic [1:0] s0, input logic [1:0] s1, input logic [2:0] op,
                         input logic bp, input logic ae);
    sel0 = s0; sel1 = s1; selOp = op; byPass = bp; accEn = ae;
  endtask

  // Issue a single transaction and check it once it reaches the output register.
  task automatic single(input string tag, input logic [31:0] exp_out, input logic exp_c);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 1'b0);
    step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_carry"}, carry, exp_c);
    chk({tag, "_zero"}, zero, exp_out == 32'd0);
    step();
  endtask

  initial begin
    logic [31:0] acc_exp [5];
    int sent, bp_i, fire0;
    acc_exp = '{32'd10, 32'd15, 32'd20, 32'd25, 32'd25};

    rst_n = 1'b0; in_bus = '0; in_valid = 1'b0; out_ready = 1'b1; accClr = 1'b0;
    set_txn(0, 0, 0, 0, 0);
    in_bus8 = '0; sel0_8 = '0; sel1_8 = '0; selOp8 = '0; in_valid8 = 1'b0;
    saw_stall = 1'b0; m_acc = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 32'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Reset with work in flight: preload acc, queue two, then reset.
    in_bus = {32'd0, 32'd3, 32'd9, 32'd7};
    set_txn(0, 0, 0, 1, 1); in_valid = 1'b1; step();
    set_txn(1, 2, 0, 0, 0); step();
    set_txn(1, 2, 1, 0, 0); step();
    in_valid = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rstmid_out_valid", out_valid, 1'b0);
    chk("rstmid_out", out, 32'd0);
    set_txn(3, 0, 0, 0, 1);
    single("rstmid_acc", 32'd0, 1'b0);

    in_bus = {32'd5, 32'd3, 32'd1, 32'hFFFF_FFFF};
    set_txn(0, 1, 0, 0, 0); single("add_carry", 32'd0, 1'b1);
    set_txn(2, 3, 1, 0, 0); single("sub_borrow", 32'hFFFF_FFFE, 1'b1);
    in_bus = {32'd5, 32'd3, 32'd4, 32'h8000_0000};
    set_txn(0, 1, 7, 0, 0); single("sra", 32'hF800_0000, 1'b0);

    // Back-to-back accumulate: preload 10, three +5, read back, clear on readback write.
    in_bus = {32'd0, 32'd0, 32'd5, 32'd10};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_txn(0, 0, 0, 1, 1);
      else if (i < 4) set_txn(1, 0, 0, 0, 1);
      else set_txn(2, 0, 0, 0, 1);
      step();
      if (i > 0) chk("acc_seq", out, acc_exp[i-1]);
    end
    in_valid = 1'b0; accClr = 1'b1; step(); accClr = 1'b0;
    chk("acc_seq_last", out, acc_exp[4]);
    set_txn(2, 0, 0, 0, 1); in_valid = 1'b1; step(); in_valid = 1'b0; step();
    chk("acc_clr_readback", out, 32'd0);
    step();

    // Backpressure: six ADDs, out_ready pattern 1,0,0,1.
    saw_stall = 1'b0; fire0 = n_fire; sent = 0; bp_i = 0;
    set_txn(0, 1, 0, 0, 0);
    while (sent < 6 && bp_i < 100) begin
      if (!in_valid) begin
        in_bus = {32'd0, 32'd0, 32'(sent + 1), $urandom};
        in_valid = 1'b1;
      end
      out_ready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
      step();
      bp_i++;
      if (accepted) begin sent++; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && bp_i < 200) begin
      out_ready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
      step();
      bp_i++;
    end
    out_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_in_ready_drop", saw_stall, 1'b1);
    chk("bp_count", n_fire - fire0, 6);

    // Randomized traffic with random backpressure, holding inputs while stalled.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bus = {$urandom, $urandom, $urandom, $urandom};
        set_txn(2'($urandom), 2'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) step();
    chk("rand_drain", q.size(), 0);
    chk("rand_idle", out_valid, 1'b0);

    // Alternate geometry: 8-bit words, eight inputs.
    in_bus8 = '0;
    in_bus8[7*8 +: 8] = 8'hA5;
    in_bus8[6*8 +: 8] = 8'h5A;
    sel0_8 = 3'd7; sel1_8 = 3'd6; selOp8 = 3'd4; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    step();
    chk("w8_valid", out_valid8, 1'b1);
    chk("w8_out", out8, 8'hFF);
    chk("w8_zero", zero8, 1'b0);
    chk("w8_carry", carry8, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_arithmetic_logic_pipelined.md
Name: cell_arithmetic_logic_pipelined

Overview:
- Parametrised successor to the combinational 4-input arithmetic/logic cell.
- Selects two operands from N_INPUTS word inputs and executes one of eight ALU ops in a 2-stage valid/ready pipeline.
- Produces zero/carry flags and keeps an internal accumulator that can stand in for operand1, for reductions in the CLB array.
- Sits between the CLB interconnect and downstream cells; backpressure propagates through in_ready.

Parameters:
- WIDTH, 32, data word width (>=8).
- N_INPUTS, 4, number of word inputs (power of 2, >=2).
- SEL_W, $clog2(N_INPUTS), operand-select width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_bus  in  N_INPUTS*WIDTH  packed inputs; input k = in_bus[k*WIDTH +: WIDTH].
- sel0  in  SEL_W  operand0 select.
- sel1  in  SEL_W  operand1 select (ignored when accEn=1).
- selOp  in  3  operation code.
- byPass  in  1  result = operand0.
- accEn  in  1  operand1 = accumulator; result is written back to the accumulator.
- accClr  in  1  clear accumulator (independent of handshake).
- in_valid  in  1  request valid.
- in_ready  out  1  cell can accept.
- out  out  WIDTH  result.
- zero  out  1  out == 0.
- carry  out  1  carry/borrow flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.

Behaviour:
- Reset (rst_n=0 at clk edge): s1_valid=0, out_valid=0, out=0, zero=0, carry=0, acc=0. Any in-flight transactions are discarded. in_ready=1 in the cycle after reset.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - Upstream must hold inputs stable while in_valid=1 and in_ready=0.
- Stage 1 (accept): registers operand0=in_bus[sel0], operand1_raw=in_bus[sel1], selOp, byPass, accEn; sets s1_valid.
- Stage 2 (execute): when s1_valid and the output register is free, computes and registers out/zero/carry and sets out_valid.
  - Output register is free when !out_valid | out_ready.
- Flow control:
  - adv2 = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | adv2 (combinational; no combinational path from in_valid).
- Latency: 2 cycles from input acceptance to out_valid with out_ready held high. Throughput is 1 per cycle.
- Stall: with out_ready=0, out/zero/carry/out_valid hold. Stage 1 fills, then in_ready drops. Nothing is lost or duplicated.
- Operand1 at execute: acc if accEn, else operand1_raw. acc is read in stage 2, so back-to-back accumulate ops see the previous result with no hazard.
- selOp encoding (a=operand0, b=operand1, sh=b[$clog2(WIDTH)-1:0]):
  - 0 ADD: a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 1 SUB: a-b; carry = 1 iff a<b unsigned (borrow).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 SLL a<<sh, 6 SRL a>>sh, 7 SRA arithmetic a>>>sh: carry=0.
- byPass=1: out=a, carry=0, zero=(a==0). selOp is ignored.
- zero = (result == 0) for every op.
- Accumulator write:
  - On adv2 with accEn=1: acc <= result (including bypass result, which allows preload).
  - accClr=1: acc <= 0 on that edge. Clear wins over a simultaneous write.
  - A transaction in stage 2 during the same cycle uses the old acc value.
- Wrap-around: ADD/SUB are modulo 2^WIDTH. acc wraps silently.

Decomposition:
- Package cell_alu_pkg: opcode localparams (OP_ADD..OP_SRA), OP_W=3.
- Sub-module alu_ext_unit (combinational: a, b, op, byPass -> result, carry) is instantiated in stage 2.
- Operand muxes are done by indexed part-select in the top module; no separate mux instance.

Test Plan:
- Reset mid-stream: 2 transactions in flight, rst_n=0 one cycle -> out_valid=0, out=0, acc=0 next cycle; no stale output appears afterwards.
- ADD carry: in0=0xFFFFFFFF, in1=0x1, sel0=0, sel1=1, selOp=0 -> 2 cycles later out=0, zero=1, carry=1.
- SUB borrow and SRA: in2=3, in3=5, SUB sel0=2, sel1=3 -> out=0xFFFFFFFE, carry=1. Then in0=0x80000000, in1=4, SRA -> out=0xF8000000, carry=0.
- Accumulate back-to-back: preload via byPass+accEn with in0=10, then 3 consecutive ADD accEn with in1=5 each cycle -> outs 10, 15, 20, 25; acc=25. accClr coinciding with the last write -> acc=0.
- Backpressure: stream of 6 ADDs with out_ready toggling 1,0,0,1,... -> in_ready drops when both stages are full; all 6 results arrive in order exactly once, and out is stable while stalled.
- Parameter sweep: WIDTH=8, N_INPUTS=8, sel0=7, sel1=6, selOp=XOR with in7=0xA5, in6=0x5A -> out=0xFF, zero=0.
